noise_shaping_ds_modulator: RTL and testbench
=============================================

// Module: noise_shaping_ds_modulator
// PURPOSE
//  Error-feedback delta-sigma modulator for the noise-shaping DAC: requantizes a fixed-point input
//  u (IN_BITS, FRAC_BITS fractional) to an OUT_BITS integer code y.
//  The quantization error is shaped by a selectable 0..3rd-order FIR.
//  Serial datapath: one output per 4 enabled clocks. Optional LFSR dither. Drives the PWM/output stage.
// PARAMETERS
//  IN_BITS    16  input width, unsigned; top IN_BITS-FRAC_BITS bits integer
//  FRAC_BITS   8  fractional bits dropped by quantizer; error width
//  OUT_BITS    9  output code width (headroom above input integer range)
// PORTS
//  clk               in   1          clock; all logic on rising edge
//  reset             in   1          synchronous, active-high reset
//  en                in   1          clock enable; low freezes all state, y_valid_out=0
//  reset_lfsr        in   1          sync reload of dither LFSR to seed
//  noise_mode        in   2          0 none, 1 rectangular dither, 2 triangular dither, 3 = none
//  n_decorrelate     in   2          extra LFSR steps per enabled clock (total steps 1+n)
//  coeff_choice      in   4          noise-shaping filter select (see BEHAVIOUR)
//  u                 in   IN_BITS    unsigned input sample, sampled in phase 0
//  u_rshift          in   3          logical right shift applied to u (attenuation)
//  y                 out  OUT_BITS   quantized output code, registered, held between updates
//  y_valid_out       out  1          1-cycle pulse when y holds a new sample
//  force_err         in   1          test: write forced_err_value into error history
//  forced_err_value  in   FRAC_BITS  forced error value
// BEHAVIOUR
//  - Reset: phase=0, acc=0, sreg[0..2]=0, y=0, y_valid_out=0, LFSR=seed 16'hACE1.
//  - 2-bit phase counter advances only when en=1; 0->1->2->3->0.
//  - Internal acc signed ACC_BITS=OUT_BITS+FRAC_BITS+2. sreg[0..2]: SREG_BITS=16, zero-extended error history, e[n-1..n-3].
//  - Phase 0: acc <= (u>>u_rshift) + dither. Phase 1: acc += c1*sreg[0]. Phase 2: acc += c2*sreg[1].
//  - Phase 3: v = acc + c3*sreg[2]. Output code is y <= clamp(v>>>FRAC_BITS, 0, 2^OUT_BITS-1).
//    Error is e = v[FRAC_BITS-1:0], or forced_err_value if force_err.
//    Shift: sreg[2]<=sreg[1], sreg[1]<=sreg[0], sreg[0]<=e. Set y_valid_out<=1.
//  - y/y_valid_out become visible the cycle after phase 3; y_valid_out cleared next clock.
//    First valid at the 4th enabled edge after reset release.
//  - coeff_choice (c1,c2,c3): 0=(1,0,0), 1=(2,-1,0), 2=(3,-3,1), 3=(0,0,0) plain truncation;
//    4..15 behave as 0. Sampled in phase 1..3 each cycle.
//  - NTF = (1-z^-1)^k; products are shift-add only (|c|<=3); no multipliers.
//  - Clamp saturates y only; e is always the raw fractional part (no wrap of y at 0 or max).
//  - Dither (macro on): mode1 adds lfsr[FRAC_BITS-1:0]-2^(FRAC_BITS-1);
//    mode2 adds the sum of two such from disjoint LFSR slices. Result is signed and in LSBs of FRAC.
//  - reset has priority over en; reset_lfsr is honoured regardless of en.
//  - Mid-sample change of u is ignored until next phase 0.
// CONFIGURATION
//  DS_NOISE_EN defined: LFSR (Galois x^16+x^14+x^13+x^11+1) and dither are present;
//    the LFSR advances 1+n_decorrelate steps per enabled clock.
//  Undefined: no LFSR; noise_mode, n_decorrelate and reset_lfsr are ignored; dither = 0.
// STRUCTURE
//  Package ds_modulator_pkg: SREG_BITS=16, LFSR_SEED, LFSR_TAPS, phase enum.
//    Also the coeff_t struct {c1,c2,c3 signed 3b} and the coeff lookup function.
//  Sub-module ds_lfsr: step count input; instantiated only under DS_NOISE_EN.
//  Everything else lives in this module.
// TESTING
//  1 Reset, en=1, u=0 -> y=0, y_valid_out low until 4th edge, then high every 4 clocks.
//  2 coeff=3, u=16'h1280, rshift=0 -> y=18 every sample; u_rshift=1, u=16'h2500 -> y=18.
//  3 coeff=0, u=16'h1280 (18.5) -> y alternates 18/19; sum of 256 samples = 4736.
//  4 coeff=2, force_err=1, forced=8'h80, u=16'h1000 -> y=16 constant after 3 samples.
//  5 coeff=2, u=16'hFFFF -> y<=259 always; u=0 -> y never 511 (clamp at 0).
//  6 en toggled low mid-sample -> sreg, acc, phase frozen; sample sequence identical to en=1 run.

Source files
------------

// File: rtl/ds_modulator_pkg.sv
// Shared types and constants for the error-feedback delta-sigma modulator.
// Contents: error-history width, dither LFSR seed/taps, serial phase enum,
//           noise-shaping coefficient triple and its lookup.
package ds_modulator_pkg;

   localparam int          SREG_BITS = 16;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Galois form of x^16+x^14+x^13+x^11+1, right-shifting.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      PH_LOAD = 2'd0,   // acc <= attenuated input + dither
      PH_TAP1 = 2'd1,   // acc += c1 * e[n-1]
      PH_TAP2 = 2'd2,   // acc += c2 * e[n-2]
      PH_OUT  = 2'd3    // v = acc + c3 * e[n-3]; quantize and emit
   } phase_e;

   typedef struct packed {
      logic signed [2:0] c1;
      logic signed [2:0] c2;
      logic signed [2:0] c3;
   } coeff_t;

   // NTF = (1 - z^-1)^k; selector 3 gives plain truncation, 4..15 fall back to 1st order.
   function automatic coeff_t coeff_lookup(input logic [3:0] sel);
      coeff_t c;
      case (sel)
         4'd1:    c = '{c1: 3'sd2, c2: -3'sd1, c3: 3'sd0};
         4'd2:    c = '{c1: 3'sd3, c2: -3'sd3, c3: 3'sd1};
         4'd3:    c = '{c1: 3'sd0, c2: 3'sd0,  c3: 3'sd0};
         default: c = '{c1: 3'sd1, c2: 3'sd0,  c3: 3'sd0};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ds_lfsr.sv
// 16-bit Galois LFSR for modulator dither, advancing 1..4 steps per enabled clock.
// Latency: new state visible the cycle after an enabled edge; reload to seed is synchronous.
// Backpressure: none; 'advance' low holds the state, reset/reset_lfsr reload regardless of advance.
// Ports: clk, reset (sync, active-high), reset_lfsr (sync reload), advance (clock enable),
//        extra_steps (additional steps beyond the first), state (current register value).
module ds_lfsr
   import ds_modulator_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        reset_lfsr,
   input  logic        advance,
   input  logic [1:0]  extra_steps,
   output logic [15:0] state
);

   logic [15:0] state_next;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

   // Unrolled chain of up to four steps; step 0 always happens.
   always_comb begin
      state_next = state;
      for (int i = 0; i < 4; i++) begin
         if (i <= int'(extra_steps)) begin
            state_next = lfsr_step(state_next);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || reset_lfsr) begin
         state <= LFSR_SEED;
      end else if (advance) begin
         state <= state_next;
      end
   end

endmodule

// File: rtl/noise_shaping_ds_modulator.sv
// Error-feedback delta-sigma requantizer: IN_BITS fixed-point u -> OUT_BITS code y, 0..3rd order shaping.
// Latency: serial, one sample per 4 enabled clocks; y/y_valid_out update the cycle after phase 3.
// Backpressure: none; en low freezes all state. Optional dither under macro DS_NOISE_EN.
// Ports: clk, reset (sync, active-high), en, reset_lfsr, noise_mode, n_decorrelate, coeff_choice,
//        u, u_rshift, force_err, forced_err_value (inputs); y, y_valid_out (outputs).
module noise_shaping_ds_modulator
   import ds_modulator_pkg::*;
#(
   parameter int IN_BITS   = 16,
   parameter int FRAC_BITS = 8,
   parameter int OUT_BITS  = 9
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 reset_lfsr,
   input  logic [1:0]           noise_mode,
   input  logic [1:0]           n_decorrelate,
   input  logic [3:0]           coeff_choice,
   input  logic [IN_BITS-1:0]   u,
   input  logic [2:0]           u_rshift,
   output logic [OUT_BITS-1:0]  y,
   output logic                 y_valid_out,
   input  logic                 force_err,
   input  logic [FRAC_BITS-1:0] forced_err_value
);

   localparam int ACC_BITS = OUT_BITS + FRAC_BITS + 2;
   localparam logic signed [ACC_BITS-1:0] Y_MAX = ACC_BITS'((1 << OUT_BITS) - 1);

   phase_e                     phase_q, phase_d;
   logic signed [ACC_BITS-1:0] acc;
   logic [SREG_BITS-1:0]       sreg [3];

   logic [IN_BITS-1:0]         u_att;
   logic signed [ACC_BITS-1:0] dither;
   logic signed [ACC_BITS-1:0] acc_load;
   coeff_t                     coeff;
   logic signed [2:0]          c_sel;
   logic [SREG_BITS-1:0]       s_sel;
   logic signed [ACC_BITS-1:0] prod;
   logic signed [ACC_BITS-1:0] acc_sum;
   logic signed [ACC_BITS-1:0] y_int;
   logic [OUT_BITS-1:0]        y_next;
   logic [FRAC_BITS-1:0]       e_next;

   // |c| <= 3, so every product is a shift, a shift plus add, or their negation.
   function automatic logic signed [ACC_BITS-1:0] shift_add(input logic signed [2:0] c,
                                                            input logic [SREG_BITS-1:0] s);
      logic signed [ACC_BITS-1:0] se;
      logic signed [ACC_BITS-1:0] r;
      se = $signed({{(ACC_BITS-SREG_BITS){1'b0}}, s});
      case (c)
         3'b001:  r = se;
         3'b010:  r = se <<< 1;
         3'b011:  r = (se <<< 1) + se;
         3'b111:  r = -se;
         3'b110:  r = -(se <<< 1);
         3'b101:  r = -((se <<< 1) + se);
         default: r = '0;
      endcase
      return r;
   endfunction

   // ---------------- phase sequencer ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q <= PH_LOAD;
      end else begin
         phase_q <= phase_d;
      end
   end

   always_comb begin
      phase_d = phase_q;
      if (en) begin
         case (phase_q)
            PH_LOAD: phase_d = PH_TAP1;
            PH_TAP1: phase_d = PH_TAP2;
            PH_TAP2: phase_d = PH_OUT;
            PH_OUT:  phase_d = PH_LOAD;
            default: phase_d = PH_LOAD;
         endcase
      end
   end

   // ---------------- dither ----------------
`ifdef DS_NOISE_EN
   localparam logic signed [ACC_BITS-1:0] HALF = ACC_BITS'(1 << (FRAC_BITS - 1));

   logic [15:0]                lfsr_state;
   logic signed [ACC_BITS-1:0] d_a;
   logic signed [ACC_BITS-1:0] d_b;

   ds_lfsr u_lfsr (
      .clk         (clk),
      .reset       (reset),
      .reset_lfsr  (reset_lfsr),
      .advance     (en),
      .extra_steps (n_decorrelate),
      .state       (lfsr_state)
   );

   // Two disjoint slices; their sum gives a triangular PDF.
   assign d_a = $signed({{(ACC_BITS-FRAC_BITS){1'b0}}, lfsr_state[FRAC_BITS-1:0]}) - HALF;
   assign d_b = $signed({{(ACC_BITS-FRAC_BITS){1'b0}}, lfsr_state[2*FRAC_BITS-1:FRAC_BITS]}) - HALF;

   always_comb begin
      dither = '0;
      case (noise_mode)
         2'd1:    dither = d_a;
         2'd2:    dither = d_a + d_b;
         default: dither = '0;
      endcase
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{noise_mode, n_decorrelate, reset_lfsr};
   assign dither     = '0;
`endif

   // ---------------- datapath ----------------
   assign u_att    = u >> u_rshift;
   assign acc_load = $signed({{(ACC_BITS-IN_BITS){1'b0}}, u_att}) + dither;
   assign coeff    = coeff_lookup(coeff_choice);

   always_comb begin
      c_sel = coeff.c1;
      s_sel = sreg[0];
      case (phase_q)
         PH_TAP2: begin
            c_sel = coeff.c2;
            s_sel = sreg[1];
         end
         PH_OUT: begin
            c_sel = coeff.c3;
            s_sel = sreg[2];
         end
         default: begin
            c_sel = coeff.c1;
            s_sel = sreg[0];
         end
      endcase
   end

   assign prod    = shift_add(c_sel, s_sel);
   assign acc_sum = acc + prod;          // in PH_OUT this is v
   assign y_int   = acc_sum >>> FRAC_BITS;

   // Saturate the code only; the fed-back error stays the raw fractional part of v.
   always_comb begin
      if (y_int < 0) begin
         y_next = '0;
      end else if (y_int > Y_MAX) begin
         y_next = Y_MAX[OUT_BITS-1:0];
      end else begin
         y_next = y_int[OUT_BITS-1:0];
      end
   end

   assign e_next = force_err ? forced_err_value : acc_sum[FRAC_BITS-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         acc         <= '0;
         sreg[0]     <= '0;
         sreg[1]     <= '0;
         sreg[2]     <= '0;
         y           <= '0;
         y_valid_out <= 1'b0;
      end else begin
         y_valid_out <= 1'b0;
         if (en) begin
            case (phase_q)
               PH_LOAD: acc <= acc_load;
               PH_TAP1: acc <= acc_sum;
               PH_TAP2: acc <= acc_sum;
               PH_OUT: begin
                  y           <= y_next;
                  sreg[2]     <= sreg[1];
                  sreg[1]     <= sreg[0];
                  sreg[0]     <= {{(SREG_BITS-FRAC_BITS){1'b0}}, e_next};
                  y_valid_out <= 1'b1;
               end
               default: acc <= acc;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_noise_shaping_ds_modulator.sv
// Testbench for noise_shaping_ds_modulator (default build, no dither).
// Reference model works per output sample: v = (u>>r) + c1*e1 + c2*e2 + c3*e3,
// y = clamp(floor(v/256)), e = v mod 256.
module tb_noise_shaping_ds_modulator;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       reset_lfsr = 1'b0;
   logic [1:0] noise_mode = 2'd0;
   logic [1:0] n_decorrelate = 2'd0;
   logic [3:0] coeff_choice = 4'd0;
   logic [15:0] u = 16'd0;
   logic [2:0] u_rshift = 3'd0;
   logic [8:0] y;
   logic       y_valid_out;
   logic       force_err = 1'b0;
   logic [7:0] forced_err_value = 8'd0;

   int checks = 0;
   int errors = 0;

   // model error history e[n-1], e[n-2], e[n-3]
   int me1, me2, me3;

   noise_shaping_ds_modulator #(.IN_BITS(16), .FRAC_BITS(8), .OUT_BITS(9)) dut (
      .clk              (clk),
      .reset            (reset),
      .en               (en),
      .reset_lfsr       (reset_lfsr),
      .noise_mode       (noise_mode),
      .n_decorrelate    (n_decorrelate),
      .coeff_choice     (coeff_choice),
      .u                (u),
      .u_rshift         (u_rshift),
      .y                (y),
      .y_valid_out      (y_valid_out),
      .force_err        (force_err),
      .forced_err_value (forced_err_value)
   );

   always #5 clk = ~clk;

   task automatic model_sample(input int uu, input int rs, input int cs, input bit fe,
                               input int fv, output int y_exp);
      int c1, c2, c3, v, q;
      case (cs)
         1:       begin c1 = 2; c2 = -1; c3 = 0; end
         2:       begin c1 = 3; c2 = -3; c3 = 1; end
         3:       begin c1 = 0; c2 = 0;  c3 = 0; end
         default: begin c1 = 1; c2 = 0;  c3 = 0; end
      endcase
      v = (uu >> rs) + c1 * me1 + c2 * me2 + c3 * me3;
      q = v >>> 8;
      y_exp = (q < 0) ? 0 : (q > 511) ? 511 : q;
      me3 = me2;
      me2 = me1;
      me1 = fe ? fv : (v & 255);
   endtask

   // Called #1 after an edge where phase returns to 0; leaves the bench in the same alignment.
   task automatic do_sample(input int uu, input int rs, input int cs, input bit fe, input int fv,
                            input bit rand_en, output int y_got, output bit timed_out);
      int k;
      u = uu[15:0];
      u_rshift = rs[2:0];
      coeff_choice = cs[3:0];
      force_err = fe;
      forced_err_value = fv[7:0];
      timed_out = 1'b1;
      for (k = 0; k < 64; k++) begin
         en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk);
         #1;
         if (y_valid_out) begin
            timed_out = 1'b0;
            break;
         end
      end
      y_got = int'(y);
      en = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      en = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      me1 = 0; me2 = 0; me3 = 0;
   endtask

   task automatic test_reset();
      u = 16'h1280;
      en = 1'b1;
      reset = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (y !== 9'd0) begin errors++; $display("FAIL reset_y: got %0d expected 0", y); end
      checks++;
      if (y_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", y_valid_out); end
      u = 16'h0000;
      coeff_choice = 4'd0;
      reset = 1'b0;
      me1 = 0; me2 = 0; me3 = 0;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (y_valid_out !== ((k % 4) == 0)) begin
            errors++;
            $display("FAIL valid_cadence edge %0d: got %0b expected %0b", k, y_valid_out, (k % 4) == 0);
         end
      end
      checks++;
      if (y !== 9'd0) begin errors++; $display("FAIL zero_input_y: got %0d expected 0", y); end
   endtask

   task automatic test_truncation();
      int yg, ye;
      bit to;
      for (int i = 0; i < 4; i++) begin
         do_sample(16'h1280, 0, 3, 1'b0, 0, 1'b0, yg, to);
         model_sample(16'h1280, 0, 3, 1'b0, 0, ye);
         checks++;
         if (to || yg != 18) begin errors++; $display("FAIL trunc_plain: got %0d (timeout %0b) expected 18", yg, to); end
      end
      for (int i = 0; i < 4; i++) begin
         do_sample(16'h2500, 1, 3, 1'b0, 0, 1'b0, yg, to);
         model_sample(16'h2500, 1, 3, 1'b0, 0, ye);
         checks++;
         if (to || yg != 18) begin errors++; $display("FAIL trunc_rshift: got %0d (timeout %0b) expected 18", yg, to); end
      end
   endtask

   task automatic test_first_order();
      int yg, ye, sum, bad;
      bit to;
      do_reset();
      sum = 0;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         do_sample(16'h1280, 0, 0, 1'b0, 0, 1'b0, yg, to);
         model_sample(16'h1280, 0, 0, 1'b0, 0, ye);
         sum += yg;
         if (to || yg != ye) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL first_order_samples: got %0d bad samples expected 0", bad); end
      checks++;
      if (sum != 4736) begin errors++; $display("FAIL first_order_sum: got %0d expected 4736", sum); end
   endtask

   task automatic test_forced_error();
      int yg, ye;
      bit to;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         do_sample(16'h1000, 0, 2, 1'b1, 8'h80, 1'b0, yg, to);
         model_sample(16'h1000, 0, 2, 1'b1, 8'h80, ye);
         checks++;
         if (to || yg != ye) begin errors++; $display("FAIL forced_model %0d: got %0d expected %0d", i, yg, ye); end
         if (i >= 3) begin
            checks++;
            if (yg != 16) begin errors++; $display("FAIL forced_const %0d: got %0d expected 16", i, yg); end
         end
      end
      force_err = 1'b0;
   endtask

   task automatic test_clamp();
      int yg, ye;
      bit to;
      for (int i = 0; i < 20; i++) begin
         do_sample(16'hFFFF, 0, 2, 1'b0, 0, 1'b0, yg, to);
         model_sample(16'hFFFF, 0, 2, 1'b0, 0, ye);
         checks++;
         if (to || yg != ye || yg > 259) begin errors++; $display("FAIL clamp_top %0d: got %0d expected %0d (<=259)", i, yg, ye); end
      end
      for (int i = 0; i < 20; i++) begin
         do_sample(0, 0, 2, 1'b0, 0, 1'b0, yg, to);
         model_sample(0, 0, 2, 1'b0, 0, ye);
         checks++;
         if (to || yg != ye || yg == 511) begin errors++; $display("FAIL clamp_bottom %0d: got %0d expected %0d", i, yg, ye); end
      end
   endtask

   task automatic test_random();
      int yg, ye, uu, rs, cs, fv;
      bit fe, to;
      for (int i = 0; i < 40; i++) begin
         uu = int'($urandom_range(0, 65535));
         rs = int'($urandom_range(0, 7));
         cs = int'($urandom_range(0, 15));
         fe = ($urandom_range(0, 7) == 0);
         fv = int'($urandom_range(0, 255));
         do_sample(uu, rs, cs, fe, fv, 1'b0, yg, to);
         model_sample(uu, rs, cs, fe, fv, ye);
         checks++;
         if (to || yg != ye) begin
            errors++;
            $display("FAIL random %0d (u=%h r=%0d c=%0d f=%0b): got %0d expected %0d", i, uu, rs, cs, fe, yg, ye);
         end
      end
   endtask

   task automatic test_en_freeze();
      int yg, ye, bad;
      int us [12];
      int cs [12];
      int ref_y [12];
      bit to;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         us[i] = int'($urandom_range(0, 65535));
         cs[i] = int'($urandom_range(0, 3));
         do_sample(us[i], 0, cs[i], 1'b0, 0, 1'b0, yg, to);
         model_sample(us[i], 0, cs[i], 1'b0, 0, ye);
         ref_y[i] = ye;
      end
      do_reset();
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         do_sample(us[i], 0, cs[i], 1'b0, 0, 1'b1, yg, to);
         checks++;
         if (to || yg != ref_y[i]) begin
            errors++;
            $display("FAIL en_toggle %0d: got %0d (timeout %0b) expected %0d", i, yg, to, ref_y[i]);
         end
      end
      // hold en low across several edges: output must not pulse or change
      en = 1'b0;
      u = 16'hFFFF;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (y_valid_out !== 1'b0 || int'(y) != ref_y[11]) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL en_low_hold: got %0d bad cycles expected 0", bad); end
      en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_truncation();
      test_first_order();
      test_forced_error();
      test_clamp();
      test_random();
      test_en_freeze();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
